rgb_pwm_breather: RTL and testbench
===================================

Name: rgb_pwm_breather

Overview:
- Parametrised multi-channel LED driver that succeeds the free-running counter blinker.
- Each channel is driven by a PWM generator with a per-channel duty value and one of four modes: OFF, STATIC, BREATHE (triangle ramp) or BLINK.
- It sits between the board top level (clk48 domain) and the active-low RGB LED pins.
- Control values are loaded through a simple write strobe from a button handler, a sequencer or the bench.

Parameters:
CHANNELS, 3, number of LED channels (≥1)
PWM_BITS, 8, PWM resolution; one period = 2^PWM_BITS ticks
PRESCALE, 188, clk48 cycles per PWM tick (≥1); 48 MHz/188/256 ≈ 1 kHz
STEP_DIV, 4, PWM periods per breathe ramp step (≥1)
BLINK_PERIODS, 250, PWM periods per blink half-cycle (≥1)

Ports:
clk48  input  1  system clock
rst  input  1  synchronous reset, active-high
wr_en  input  1  write strobe, one cycle
wr_chan  input  max(1,$clog2(CHANNELS))  channel index for the write
wr_mode  input  2  mode: 0 OFF, 1 STATIC, 2 BREATHE, 3 BLINK
wr_duty  input  PWM_BITS  duty or breathe peak
led_n  output  CHANNELS  active-low LED drive, registered
period_strobe  output  1  one-cycle pulse at the start of each PWM period

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk48, rst).
- Reset values:
  - led_n all ones; period_strobe 0.
  - All modes OFF; all duty values 0.
  - Prescaler, pwm_cnt, blink counter, blink phase, ramps and step counters all 0; ramp direction up.
  - rst asserted mid-operation gives the same state on the next edge, with no residual pulse.
- Prescaler:
  - Counts 0..PRESCALE-1.
  - tick = (prescaler == PRESCALE-1), then the prescaler wraps to 0.
- pwm_cnt (PWM_BITS wide):
  - Increments on tick and wraps from 2^PWM_BITS-1 to 0.
  - Boundary = tick && pwm_cnt all ones.
- On the boundary edge:
  - Each channel's effective level is latched into a shadow register.
  - period_strobe is asserted for the following single cycle, aligned with the first cycle of pwm_cnt == 0.
- Effective level per channel:
  - OFF: 0.
  - STATIC: duty.
  - BREATHE: ramp.
  - BLINK: duty when blink phase = 1, else 0.
- Output: led_n[i] <= ~(pwm_cnt < shadow[i]). This is one cycle of latency after pwm_cnt changes.
  - Duty 0 never lights the LED.
  - Duty 2^PWM_BITS-1 lights it for all but one tick per period.
- BREATHE:
  - Per-channel step counter counts boundaries.
  - Every STEP_DIV boundaries the ramp moves ±1.
  - Direction flips to down on reaching duty and to up on reaching 0.
  - If duty = 0 the ramp stays at 0.
  - If duty is lowered below the current ramp, the ramp steps down toward it and ramps normally from then on.
- BLINK:
  - One shared counter counts boundaries.
  - The blink phase toggles every BLINK_PERIODS boundaries.
  - The phase starts at 0 after reset.
- Writes:
  - wr_en updates mode[wr_chan] and duty[wr_chan] on the same edge.
  - wr_chan ≥ CHANNELS is ignored.
  - A write whose mode differs from the current mode resets that channel's ramp to 0, direction up, and its step counter to 0.
- Write timing:
  - A write never changes led_n mid-period.
  - It is visible from the next boundary latch.
  - A write on the boundary cycle itself is latched with the old values and takes effect one period later.

Optional Feature:
GAMMA_CORRECT_EN
- Defined: the shadow latch stores (eff*(eff+1)) >> PWM_BITS instead of eff, giving a perceptual gamma of about 2.
  - Mapping for PWM_BITS=8: 0→0, 1→0, 128→64, 255→255.
  - One registered multiply stage is permitted inside the latch path; boundary timing is unchanged.
- Undefined: linear mapping, no multiplier.

Test Plan:
Bench parameters: PRESCALE=2, PWM_BITS=4, CHANNELS=3, STEP_DIV=1, BLINK_PERIODS=2.
- Reset: hold rst 10 cycles, then release with no writes → led_n=3'b111 and period_strobe=0 throughout; first period_strobe 32 cycles after release.
- STATIC levels:
  - Write ch0 mode 1 duty 4 → from the next boundary, led_n[0] is low 8 of every 32 cycles, starting one cycle after pwm_cnt=0.
  - Duty 15 → low 30 of 32 cycles.
  - Duty 0 → never low.
- Boundary write: write ch1 STATIC duty 8 exactly on the boundary cycle → the following period is unaffected; the next period is low 16 cycles.
- BREATHE: write ch2 mode 2 duty 3 → per-period low counts (×2 cycles) follow ramp 0,1,2,3,2,1,0,1,…; a rewrite with mode 1 then mode 2 restarts the ramp at 0.
- BLINK and ignored write:
  - ch0 mode 3 duty 15 → 2 periods lit 30/32, then 2 periods dark, repeating.
  - Write with wr_chan=3 → no channel changes.
- GAMMA_CORRECT_EN build: STATIC duty 15 → 15 ticks; duty 8 → (8*9)>>4 = 4 ticks lit per period.

Source files
------------

// File: rtl/rgb_pwm_breather_if.sv
// Control-write bundle for rgb_pwm_breather.
// Ports: wr_en (one-cycle strobe), wr_chan (channel index), wr_mode (0 OFF,
//   1 STATIC, 2 BREATHE, 3 BLINK), wr_duty (duty or breathe peak).
// master = the writer (button handler / sequencer / bench), slave = the LED driver.
interface rgb_pwm_breather_if #(
  parameter int CHANNELS = 3,
  parameter int PWM_BITS = 8
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                wr_en;
  logic [CW-1:0]       wr_chan;
  logic [1:0]          wr_mode;
  logic [PWM_BITS-1:0] wr_duty;

  modport master (output wr_en, output wr_chan, output wr_mode, output wr_duty);
  modport slave  (input  wr_en, input  wr_chan, input  wr_mode, input  wr_duty);
endinterface

// File: rtl/rgb_pwm_breather.sv
// Multi-channel PWM LED driver with OFF / STATIC / BREATHE / BLINK modes per channel.
// Ports: clk48, rst (sync, active-high), wr (control write bundle, slave),
//   led_n (registered active-low LED drive), period_strobe (pulse at PWM period start).
// Optional macro GAMMA_CORRECT_EN: shadow latch stores (eff*(eff+1))>>PWM_BITS instead of eff.
module rgb_pwm_breather #(
  parameter int CHANNELS      = 3,
  parameter int PWM_BITS      = 8,
  parameter int PRESCALE      = 188,
  parameter int STEP_DIV      = 4,
  parameter int BLINK_PERIODS = 250
) (
  input  logic                clk48,
  input  logic                rst,
  rgb_pwm_breather_if.slave   wr,
  output logic [CHANNELS-1:0] led_n,
  output logic                period_strobe
);

  localparam int CW  = (CHANNELS > 1)      ? $clog2(CHANNELS)      : 1;
  localparam int PSW = (PRESCALE > 1)      ? $clog2(PRESCALE)      : 1;
  localparam int SW  = (STEP_DIV > 1)      ? $clog2(STEP_DIV)      : 1;
  localparam int BW  = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_STATIC  = 2'd1,
    MODE_BREATHE = 2'd2,
    MODE_BLINK   = 2'd3
  } mode_e;

  logic [PSW-1:0]      presc_q, presc_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic [BW-1:0]       blink_cnt_q, blink_cnt_d;
  logic                blink_ph_q, blink_ph_d;
  logic                strobe_q, strobe_d;
  logic [CHANNELS-1:0] led_q, led_d;

  mode_e               mode_q   [CHANNELS];
  mode_e               mode_d   [CHANNELS];
  logic [PWM_BITS-1:0] duty_q   [CHANNELS];
  logic [PWM_BITS-1:0] duty_d   [CHANNELS];
  logic [PWM_BITS-1:0] ramp_q   [CHANNELS];
  logic [PWM_BITS-1:0] ramp_d   [CHANNELS];
  logic                up_q     [CHANNELS];
  logic                up_d     [CHANNELS];
  logic [SW-1:0]       step_q   [CHANNELS];
  logic [SW-1:0]       step_d   [CHANNELS];
  logic [PWM_BITS-1:0] shadow_q [CHANNELS];
  logic [PWM_BITS-1:0] shadow_d [CHANNELS];
  logic [PWM_BITS-1:0] eff      [CHANNELS];

  logic tick;
  logic boundary;

  assign tick     = (presc_q == PSW'(PRESCALE - 1));
  assign boundary = tick & (&pwm_q);

  function automatic logic [PWM_BITS-1:0] map_level(input logic [PWM_BITS-1:0] e);
`ifdef GAMMA_CORRECT_EN
    logic [2*PWM_BITS-1:0] a;
    logic [2*PWM_BITS-1:0] prod;
    a    = {{PWM_BITS{1'b0}}, e};
    // e*(e+1) never exceeds 2*PWM_BITS bits, so the upper half is the result.
    prod = a * (a + 1'b1);
    return prod[2*PWM_BITS-1:PWM_BITS];
`else
    return e;
`endif
  endfunction

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      eff[i] = '0;
      case (mode_q[i])
        MODE_STATIC:  eff[i] = duty_q[i];
        MODE_BREATHE: eff[i] = ramp_q[i];
        MODE_BLINK:   eff[i] = blink_ph_q ? duty_q[i] : '0;
        default:      eff[i] = '0;
      endcase
    end
  end

  always_comb begin
    presc_d     = tick ? '0 : presc_q + 1'b1;
    pwm_d       = tick ? pwm_q + 1'b1 : pwm_q;
    blink_cnt_d = blink_cnt_q;
    blink_ph_d  = blink_ph_q;
    strobe_d    = boundary;

    if (boundary) begin
      if (blink_cnt_q == BW'(BLINK_PERIODS - 1)) begin
        blink_cnt_d = '0;
        blink_ph_d  = ~blink_ph_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end

    for (int i = 0; i < CHANNELS; i++) begin
      mode_d[i]   = mode_q[i];
      duty_d[i]   = duty_q[i];
      ramp_d[i]   = ramp_q[i];
      up_d[i]     = up_q[i];
      step_d[i]   = step_q[i];
      shadow_d[i] = boundary ? map_level(eff[i]) : shadow_q[i];
      // Compare against the current count so the LED lags pwm_cnt by one cycle.
      led_d[i]    = ~(pwm_q < shadow_q[i]);

      if (boundary && (mode_q[i] == MODE_BREATHE)) begin
        if (step_q[i] == SW'(STEP_DIV - 1)) begin
          step_d[i] = '0;
          if (duty_q[i] == '0) begin
            ramp_d[i] = '0;
            up_d[i]   = 1'b1;
          end else if (up_q[i] && (ramp_q[i] < duty_q[i])) begin
            ramp_d[i] = ramp_q[i] + 1'b1;
            up_d[i]   = ((ramp_q[i] + 1'b1) != duty_q[i]);
          end else if (ramp_q[i] != '0) begin
            // Covers both the normal descent and a ramp left above a lowered peak.
            ramp_d[i] = ramp_q[i] - 1'b1;
            up_d[i]   = (ramp_q[i] == PWM_BITS'(1));
          end else begin
            up_d[i]   = 1'b1;
          end
        end else begin
          step_d[i] = step_q[i] + 1'b1;
        end
      end

      // Writes override the boundary update; the shadow already took the old values.
      if (wr.wr_en && (wr.wr_chan == CW'(i))) begin
        mode_d[i] = mode_e'(wr.wr_mode);
        duty_d[i] = wr.wr_duty;
        if (mode_e'(wr.wr_mode) != mode_q[i]) begin
          ramp_d[i] = '0;
          up_d[i]   = 1'b1;
          step_d[i] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk48) begin
    if (rst) begin
      presc_q     <= '0;
      pwm_q       <= '0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
      strobe_q    <= 1'b0;
      led_q       <= '1;
      for (int i = 0; i < CHANNELS; i++) begin
        mode_q[i]   <= MODE_OFF;
        duty_q[i]   <= '0;
        ramp_q[i]   <= '0;
        up_q[i]     <= 1'b1;
        step_q[i]   <= '0;
        shadow_q[i] <= '0;
      end
    end else begin
      presc_q     <= presc_d;
      pwm_q       <= pwm_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
      strobe_q    <= strobe_d;
      led_q       <= led_d;
      for (int i = 0; i < CHANNELS; i++) begin
        mode_q[i]   <= mode_d[i];
        duty_q[i]   <= duty_d[i];
        ramp_q[i]   <= ramp_d[i];
        up_q[i]     <= up_d[i];
        step_q[i]   <= step_d[i];
        shadow_q[i] <= shadow_d[i];
      end
    end
  end

  assign led_n         = led_q;
  assign period_strobe = strobe_q;

endmodule

// File: tb/tb_rgb_pwm_breather.sv
// Bench for rgb_pwm_breather: directed period measurements plus random writes,
// with a period-level reference model compared on every cycle.
module tb_rgb_pwm_breather;
  localparam int CH     = 3;
  localparam int PB     = 4;
  localparam int PS     = 2;
  localparam int SD     = 1;
  localparam int BP     = 2;
  localparam int PERIOD = PS * (1 << PB);

  logic          clk48 = 1'b0;
  logic          rst   = 1'b1;
  logic [CH-1:0] led_n;
  logic          period_strobe;

  rgb_pwm_breather_if #(.CHANNELS(CH), .PWM_BITS(PB)) wif ();

  rgb_pwm_breather #(
    .CHANNELS(CH), .PWM_BITS(PB), .PRESCALE(PS), .STEP_DIV(SD), .BLINK_PERIODS(BP)
  ) dut (
    .clk48(clk48), .rst(rst), .wr(wif), .led_n(led_n), .period_strobe(period_strobe)
  );

  always #5 clk48 = ~clk48;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference model: one position counter per period, levels from mode rules.
  int m_mode [CH];
  int m_duty [CH];
  int m_nb   [CH];   // boundaries seen since entering BREATHE
  int m_shad [CH];
  int m_pos;
  int m_bcount;      // boundaries since reset
  logic [CH-1:0] exp_led;
  logic          exp_strobe;

  function automatic int tri_f(int n, int d);
    int r;
    if (d == 0) return 0;
    r = n % (2 * d);
    return (r <= d) ? r : 2 * d - r;
  endfunction

  function automatic int level(int i);
    int e;
    case (m_mode[i])
      1:       e = m_duty[i];
      2:       e = tri_f(m_nb[i] / SD, m_duty[i]);
      3:       e = (((m_bcount / BP) % 2) == 1) ? m_duty[i] : 0;
      default: e = 0;
    endcase
`ifdef GAMMA_CORRECT_EN
    e = (e * (e + 1)) >> PB;
`endif
    return e;
  endfunction

  initial begin
    forever begin
      @(posedge clk48);
      if (rst) begin
        for (int i = 0; i < CH; i++) begin
          m_mode[i] = 0; m_duty[i] = 0; m_nb[i] = 0; m_shad[i] = 0;
        end
        m_pos = 0; m_bcount = 0; exp_led = '1; exp_strobe = 1'b0;
      end else begin
        for (int i = 0; i < CH; i++) exp_led[i] = !((m_pos / PS) < m_shad[i]);
        exp_strobe = (m_pos == PERIOD - 1);
        if (exp_strobe) begin
          for (int i = 0; i < CH; i++) m_shad[i] = level(i);
          for (int i = 0; i < CH; i++) if (m_mode[i] == 2) m_nb[i]++;
          m_bcount++;
        end
        m_pos = (m_pos + 1) % PERIOD;
        if (wif.wr_en && int'(wif.wr_chan) < CH) begin
          if (m_mode[wif.wr_chan] != int'(wif.wr_mode)) m_nb[wif.wr_chan] = 0;
          m_mode[wif.wr_chan] = int'(wif.wr_mode);
          m_duty[wif.wr_chan] = int'(wif.wr_duty);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk48);
      if (chk_en) begin
        checks++;
        if (led_n !== exp_led) begin
          errors++;
          if (errors < 20) $display("FAIL led_n: got %b expected %b at %0t", led_n, exp_led, $time);
        end
        checks++;
        if (period_strobe !== exp_strobe) begin
          errors++;
          if (errors < 20) $display("FAIL period_strobe: got %b expected %b at %0t", period_strobe, exp_strobe, $time);
        end
      end
    end
  end

  task automatic check_eq(string name, int got, int expv);
    checks++;
    if (got != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, expv);
    end
  endtask

  // Called at a negedge; the write is captured on the following posedge.
  task automatic wr(int c, int m, int d);
    wif.wr_en   = 1'b1;
    wif.wr_chan = 2'(c);
    wif.wr_mode = 2'(m);
    wif.wr_duty = 4'(d);
    @(negedge clk48);
    wif.wr_en   = 1'b0;
  endtask

  task automatic wait_strobe();
    int k;
    k = 0;
    do begin
      @(negedge clk48);
      k++;
    end while (!period_strobe && k < 2 * PERIOD);
    if (!period_strobe) begin
      checks++;
      errors++;
      $display("FAIL wait_strobe: got no strobe required one within %0d cycles", 2 * PERIOD);
    end
  endtask

  // Starts on the strobe negedge, counts low cycles over one full period.
  task automatic count_period(int c, output int n);
    n = 0;
    for (int k = 0; k < PERIOD; k++) begin
      if (k > 0) @(negedge clk48);
      if (!led_n[c]) n++;
    end
  endtask

  task automatic measure(int c, output int n);
    wait_strobe();
    count_period(c, n);
  endtask

  int n;
  int k;
  int e4, e15, e8;
  int br_exp [8];
  int bl [8];

  initial begin
`ifdef GAMMA_CORRECT_EN
    e4 = 2; e15 = 30; e8 = 8;
    br_exp = '{0, 0, 0, 0, 0, 0, 0, 0};
`else
    e4 = 8; e15 = 30; e8 = 16;
    br_exp = '{0, 2, 4, 6, 4, 2, 0, 2};
`endif
    wif.wr_en = 1'b0; wif.wr_chan = '0; wif.wr_mode = '0; wif.wr_duty = '0;

    // Reset and idle
    repeat (2) @(negedge clk48);
    chk_en = 1'b1;
    repeat (8) @(negedge clk48);
    rst = 1'b0;
    k = 0;
    do begin
      @(negedge clk48);
      k++;
      if (!period_strobe) check_eq("idle_led_n", int'(led_n), 7);
    end while (!period_strobe && k < 40);
    check_eq("first_strobe_delay", k, 32);

    // STATIC levels on ch0
    wr(0, 1, 4);  measure(0, n); check_eq("static_duty4", n, e4);
    wr(0, 1, 15); measure(0, n); check_eq("static_duty15", n, e15);
    wr(0, 1, 0);  measure(0, n); check_eq("static_duty0", n, 0);

    // Write landing exactly on the boundary edge
    wait_strobe();
    repeat (PERIOD - 1) @(negedge clk48);
    wr(1, 1, 8);
    check_eq("boundary_strobe", int'(period_strobe), 1);
    count_period(1, n); check_eq("boundary_old_period", n, 0);
    measure(1, n);      check_eq("boundary_new_period", n, e8);

    // BREATHE ramp on ch2, then restart via mode change
    wr(2, 2, 3);
    for (int i = 0; i < 8; i++) begin
      measure(2, n);
      check_eq($sformatf("breathe_p%0d", i), n, br_exp[i]);
    end
    wr(2, 1, 3);
    wr(2, 2, 3);
    measure(2, n); check_eq("breathe_restart0", n, br_exp[0]);
    measure(2, n); check_eq("breathe_restart1", n, br_exp[1]);

    // BLINK on ch0: two lit, two dark
    wr(0, 3, 15);
    for (int i = 0; i < 8; i++) measure(0, bl[i]);
    for (int i = 0; i < 8; i++) check_eq("blink_level", int'(bl[i] == 0 || bl[i] == 30), 1);
    for (int i = 0; i < 6; i++) check_eq("blink_pattern", bl[i + 2], 30 - bl[i]);

    // Out-of-range channel is ignored
    wr(3, 1, 9);
    measure(1, n); check_eq("ignored_write_ch1", n, e8);

    // Mid-run reset
    rst = 1'b1;
    @(negedge clk48);
    check_eq("midreset_led_n", int'(led_n), 7);
    check_eq("midreset_strobe", int'(period_strobe), 0);
    repeat (2) @(negedge clk48);
    rst = 1'b0;

    // Random writes; a BREATHE rewrite keeps its peak so the ramp stays a plain triangle
    for (int it = 0; it < 300; it++) begin
      int c, m, d;
      repeat ($urandom_range(0, 45)) @(negedge clk48);
      c = int'($urandom_range(0, 3));
      m = int'($urandom_range(0, 3));
      d = int'($urandom_range(0, 15));
      if (c < CH && m == 2 && m_mode[c] == 2) d = m_duty[c];
      wr(c, m, d);
    end
    repeat (2 * PERIOD) @(negedge clk48);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
